// File: rtl/addsub_serial_ctrl.sv
// Serial multi-nibble adder/subtractor: one 4-bit slice per cycle, LSB first, with carry/overflow/zero flags.
// Optional macro SERAS_SAT_EN: saturate the result to the signed extreme on overflow.
module addsub_serial_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   SerAS_i_Clk,
    input  logic                   SerAS_i_Rst,
    input  logic                   SerAS_i_Valid,
    output logic                   SerAS_o_Ready,
    input  logic [4*NIBBLES-1:0]   SerAS_i_A,
    input  logic [4*NIBBLES-1:0]   SerAS_i_B,
    input  logic                   SerAS_i_fSub,
    output logic                   SerAS_o_Valid,
    input  logic                   SerAS_i_Ready,
    output logic [4*NIBBLES-1:0]   SerAS_o_S,
    output logic                   SerAS_o_C,
    output logic                   SerAS_o_V,
    output logic                   SerAS_o_Z
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state;
    state_t            nextState;
    logic [W-1:0]      aReg;
    logic [W-1:0]      bReg;
    logic              subReg;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [W-1:0]      sWork;
    logic              readyReg;
    logic              validReg;
    logic [W-1:0]      sOut;
    logic              cOut;
    logic              vOut;
    logic              zOut;

    logic [3:0]        nibA;
    logic [3:0]        nibB;
    logic [4:0]        nibSum;
    logic [W-1:0]      sWorkNext;
    logic [W-1:0]      sFinal;
    logic              vNext;
    logic              isLast;
    logic              readyNext;
    logic              validNext;

    assign isLast = (idx == IDXW'(NIBBLES - 1));

    // State register
    always_ff @(posedge SerAS_i_Clk) begin
        if (SerAS_i_Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (SerAS_i_Valid) nextState = CALC;
            CALC:    if (isLast) nextState = DONE;
            DONE:    if (SerAS_i_Ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output / datapath next values: one slice of add/sub per cycle
    always_comb begin
        nibA      = aReg[{idx, 2'b00} +: 4];
        nibB      = bReg[{idx, 2'b00} +: 4] ^ {4{subReg}};
        nibSum    = {1'b0, nibA} + {1'b0, nibB} + {4'b0000, carry};
        sWorkNext = sWork;
        sWorkNext[{idx, 2'b00} +: 4] = nibSum[3:0];
        // carry into the MSB recovered from the sum bit, compared with carry out
        vNext     = (nibA[3] ^ nibB[3] ^ nibSum[3]) ^ nibSum[4];
        sFinal    = sWorkNext;
`ifdef SERAS_SAT_EN
        if (vNext) begin
            sFinal = aReg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        readyNext = (nextState == IDLE);
        validNext = (nextState == DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge SerAS_i_Clk) begin
        if (SerAS_i_Rst) begin
            readyReg <= 1'b1;
            validReg <= 1'b0;
            aReg     <= '0;
            bReg     <= '0;
            subReg   <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            sWork    <= '0;
            sOut     <= '0;
            cOut     <= 1'b0;
            vOut     <= 1'b0;
            zOut     <= 1'b0;
        end else begin
            readyReg <= readyNext;
            validReg <= validNext;
            case (state)
                IDLE: begin
                    if (SerAS_i_Valid) begin
                        aReg   <= SerAS_i_A;
                        bReg   <= SerAS_i_B;
                        subReg <= SerAS_i_fSub;
                        carry  <= SerAS_i_fSub;
                        idx    <= '0;
                    end
                end
                CALC: begin
                    sWork <= sWorkNext;
                    carry <= nibSum[4];
                    idx   <= idx + IDXW'(1);
                    if (isLast) begin
                        sOut <= sFinal;
                        cOut <= nibSum[4];
                        vOut <= vNext;
                        zOut <= (sFinal == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign SerAS_o_Ready = readyReg;
    assign SerAS_o_Valid = validReg;
    assign SerAS_o_S     = sOut;
    assign SerAS_o_C     = cOut;
    assign SerAS_o_V     = vOut;
    assign SerAS_o_Z     = zOut;

endmodule
